// File: rtl/dbus_arbiter_if.sv
// dbus_arbiter_if: CPU, DMA and data-memory bus signals around the data-bus arbiter
// slave  : arbiter side (takes requests and mem_rdata; drives grants, read returns and mem strobes)
// master : requester/memory side (drives requests and mem_rdata)
interface dbus_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              cpu_req, cpu_we, cpu_gnt, cpu_stall, cpu_rvalid;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
    logic              dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid, dma_err;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata, dma_rdata;
    logic              mem_rd, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_lock, dma_addr, dma_wdata, mem_rdata,
        output cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata, dma_err,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, dma_req, dma_we, dma_lock, dma_addr, dma_wdata, mem_rdata,
        input  cpu_gnt, cpu_stall, cpu_rvalid, cpu_rdata, dma_gnt, dma_rvalid, dma_rdata, dma_err,
               mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// dbus_arbiter: shares the single-port data memory between the CPU MEM stage and a DMA engine
// clk   : system clock
// reset : synchronous active-high reset
// bus   : dbus_arbiter_if.slave (CPU/DMA request ports, read returns, cpu_stall, dma_err, memory strobes)
module dbus_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4,
    parameter int STARVE_LIM = 8,
    parameter int PERIPH_BIT = 30
) (
    input logic clk,
    input logic reset,
    dbus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, CPU, DMA_BURST} state_t;
    state_t state, state_n;
    logic [3:0] burst_cnt, burst_n, starve_cnt, starve_n, cnt_inc;
    logic blk, blk_n, cpu_per, dma_per, dma_pri, cpu_gnt, dma_gnt, cpu_mem, dma_mem, lock_gnt;
    logic cpu_rv, dma_rv, dma_rz;
    logic [DATA_W-1:0] cpu_hold, dma_hold;
    // blk keeps a locked DMA from starting a new burst right after one ran to MAX_BURST,
    // until the CPU gets a grant or leaves the bus idle for a cycle.
    always_comb begin
        cpu_per = bus.cpu_addr[PERIPH_BIT];
        dma_per = bus.dma_addr[PERIPH_BIT];
        dma_pri = (bus.dma_lock & ~blk) | (starve_cnt == 4'(STARVE_LIM));
        // CPU peripheral accesses never occupy memory, so they do not contend with the DMA
        dma_gnt = ~reset & bus.dma_req & (~(bus.cpu_req & ~cpu_per) | dma_pri);
        cpu_gnt = ~reset & bus.cpu_req & (cpu_per | ~dma_gnt);
        cpu_mem = cpu_gnt & ~cpu_per;
        dma_mem = dma_gnt & ~dma_per;
        bus.cpu_gnt = cpu_gnt;
        bus.dma_gnt = dma_gnt;
        bus.cpu_stall = ~reset & bus.cpu_req & ~cpu_gnt;
        bus.dma_err = dma_gnt & dma_per;
        bus.mem_rd = dma_mem ? ~bus.dma_we : cpu_mem & ~bus.cpu_we;
        bus.mem_wr = dma_mem ? bus.dma_we : cpu_mem & bus.cpu_we;
        bus.mem_addr = dma_mem ? bus.dma_addr : cpu_mem ? bus.cpu_addr : '0;
        bus.mem_wdata = dma_mem ? bus.dma_wdata : cpu_mem ? bus.cpu_wdata : '0;
        bus.cpu_rvalid = ~reset & cpu_rv;
        bus.dma_rvalid = ~reset & dma_rv;
        bus.cpu_rdata = reset ? '0 : cpu_rv ? bus.mem_rdata : cpu_hold;
        bus.dma_rdata = reset ? '0 : dma_rv ? (dma_rz ? '0 : bus.mem_rdata) : dma_hold;
        lock_gnt = dma_gnt & bus.dma_lock & ~blk;
        cnt_inc = (state == DMA_BURST) ? burst_cnt + 4'd1 : 4'd1;
        state_n = lock_gnt ? ((cnt_inc == 4'(MAX_BURST)) ? IDLE : DMA_BURST) : cpu_gnt ? CPU : IDLE;
        burst_n = lock_gnt ? cnt_inc : '0;
        blk_n = (lock_gnt & (cnt_inc == 4'(MAX_BURST))) | (blk & bus.cpu_req & ~cpu_gnt);
        starve_n = dma_gnt ? '0 : (bus.dma_req & (starve_cnt != 4'(STARVE_LIM))) ? starve_cnt + 4'd1 : starve_cnt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            burst_cnt <= '0;
            starve_cnt <= '0;
            blk <= 1'b0;
            cpu_rv <= 1'b0;
            dma_rv <= 1'b0;
            dma_rz <= 1'b0;
            cpu_hold <= '0;
            dma_hold <= '0;
        end else begin
            state <= state_n;
            burst_cnt <= burst_n;
            starve_cnt <= starve_n;
            blk <= blk_n;
            cpu_rv <= cpu_mem & ~bus.cpu_we;
            dma_rv <= dma_gnt & ~bus.dma_we;
            dma_rz <= dma_per;
            cpu_hold <= bus.cpu_rdata;
            dma_hold <= bus.dma_rdata;
        end
    end
endmodule

// File: tb/tb_dbus_arbiter.sv
// tb_dbus_arbiter: directed vector table plus conflict/burst sequences for dbus_arbiter
module tb_dbus_arbiter;
    localparam logic [31:0] A10 = 32'h10, P = 32'h4000_0008, DB = 32'hDEAD_BEEF;
    localparam logic [31:0] AA = 32'h1111_AAAA, BB = 32'h2222_BBBB, CW = 32'h1111_0000, DW = 32'h2222_0000;
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] caddr, daddr;
        logic [7:0]  flags;
        logic [31:0] maddr, mwd, crd, drd;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [31:0] rd_q = '0;
    logic [31:0] mem [0:63];
    int checks = 0;
    int errors = 0;
    vec_t tbl [22];
    dbus_arbiter_if bus ();
    dbus_arbiter dut (.clk(clk), .reset(reset), .bus(bus.slave));
    always #5 clk = ~clk;
    assign bus.mem_rdata = rd_q;
    always @(posedge clk) if (bus.mem_rd) rd_q <= mem[bus.mem_addr[7:2]];
    task automatic cyc(input logic [5:0] c, input logic [31:0] ca, input logic [31:0] da);
        @(negedge clk);
        {reset, bus.cpu_req, bus.cpu_we, bus.dma_req, bus.dma_we, bus.dma_lock} = c;
        bus.cpu_addr = ca;
        bus.dma_addr = da;
        #1;
    endtask
    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] got %h expected %h", nm, idx, act, exp);
        end
    endtask
    function automatic logic [31:0] flags();
        return {24'd0, bus.cpu_gnt, bus.cpu_stall, bus.cpu_rvalid, bus.dma_gnt, bus.dma_rvalid, bus.dma_err,
                bus.mem_rd, bus.mem_wr};
    endfunction
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'hA000_0000 + i;
        mem[1] = AA;
        mem[2] = BB;
        mem[4] = DB;
        {bus.cpu_req, bus.cpu_we, bus.dma_req, bus.dma_we, bus.dma_lock} = '0;
        bus.cpu_addr = '0;
        bus.dma_addr = '0;
        bus.cpu_wdata = CW;
        bus.dma_wdata = DW;
        tbl = '{
            '{6'b110101, A10, 32'h8, 8'b0000_0000, 32'h0, 32'h0, 32'h0, 32'h0},
            '{6'b100000, 32'h0, 32'h0, 8'b0000_0000, 32'h0, 32'h0, 32'h0, 32'h0},
            '{6'b010000, A10, 32'h0, 8'b1000_0010, A10, CW, 32'h0, 32'h0},
            '{6'b000000, 32'h0, 32'h0, 8'b0010_0000, 32'h0, 32'h0, DB, 32'h0},
            '{6'b000000, 32'h0, 32'h0, 8'b0000_0000, 32'h0, 32'h0, DB, 32'h0},
            '{6'b010000, 32'h4, 32'h0, 8'b1000_0010, 32'h4, CW, DB, 32'h0},
            '{6'b000100, 32'h0, 32'h8, 8'b0011_0010, 32'h8, DW, AA, 32'h0},
            '{6'b000000, 32'h0, 32'h0, 8'b0000_1000, 32'h0, 32'h0, AA, BB},
            '{6'b000110, 32'h0, P, 8'b0001_0100, 32'h0, 32'h0, AA, BB},
            '{6'b000100, 32'h0, P, 8'b0001_0100, 32'h0, 32'h0, AA, BB},
            '{6'b000000, 32'h0, 32'h0, 8'b0000_1000, 32'h0, 32'h0, AA, 32'h0},
            '{6'b010100, 32'h4000_0000, 32'h8, 8'b1001_0010, 32'h8, DW, AA, 32'h0},
            '{6'b000000, 32'h0, 32'h0, 8'b0000_1000, 32'h0, 32'h0, AA, BB},
            '{6'b011000, 32'h20, 32'h0, 8'b1000_0001, 32'h20, CW, AA, BB},
            '{6'b010100, A10, 32'h8, 8'b1000_0010, A10, CW, AA, BB},
            '{6'b000000, 32'h0, 32'h0, 8'b0010_0000, 32'h0, 32'h0, DB, BB},
            '{6'b010111, A10, 32'h24, 8'b0101_0001, 32'h24, DW, DB, BB},
            '{6'b000000, 32'h0, 32'h0, 8'b0000_0000, 32'h0, 32'h0, DB, BB},
            '{6'b010101, A10, 32'h8, 8'b0101_0010, 32'h8, DW, DB, BB},
            '{6'b110101, A10, 32'h8, 8'b0000_0000, 32'h0, 32'h0, 32'h0, 32'h0},
            '{6'b010000, A10, 32'h0, 8'b1000_0010, A10, CW, 32'h0, 32'h0},
            '{6'b000000, 32'h0, 32'h0, 8'b0010_0000, 32'h0, 32'h0, DB, 32'h0}
        };
        for (int i = 0; i < 22; i++) begin
            cyc(tbl[i].ctl, tbl[i].caddr, tbl[i].daddr);
            chk("flags", i, flags(), {24'd0, tbl[i].flags});
            chk("mem_addr", i, bus.mem_addr, tbl[i].maddr);
            chk("mem_wdata", i, bus.mem_wdata, tbl[i].mwd);
            chk("cpu_rdata", i, bus.cpu_rdata, tbl[i].crd);
            chk("dma_rdata", i, bus.dma_rdata, tbl[i].drd);
        end
        // unlocked conflict: eight CPU grants, then one starvation-forced DMA grant
        cyc(6'b100000, 32'h0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            cyc(6'b010100, A10, 32'h8);
            chk("starve_gnt", k, {29'd0, bus.cpu_gnt, bus.cpu_stall, bus.dma_gnt}, (k % 9 == 8) ? 32'b011 : 32'b100);
            chk("starve_addr", k, bus.mem_addr, (k % 9 == 8) ? 32'h8 : A10);
        end
        // locked bursts: four DMA beats, one CPU grant, repeat
        cyc(6'b100000, 32'h0, 32'h0);
        for (int k = 0; k < 15; k++) begin
            cyc(6'b010101, A10, 32'h8);
            chk("burst_gnt", k, {29'd0, bus.cpu_gnt, bus.cpu_stall, bus.dma_gnt}, (k % 5 == 4) ? 32'b100 : 32'b011);
        end
        // an idle CPU cycle after a full burst also lets the DMA start a new one
        cyc(6'b100000, 32'h0, 32'h0);
        for (int k = 0; k < 10; k++) begin
            cyc((k == 4) ? 6'b000101 : 6'b010101, A10, 32'h8);
            chk("reentry_gnt", k, {29'd0, bus.cpu_gnt, bus.cpu_stall, bus.dma_gnt},
                (k == 9) ? 32'b100 : (k == 4) ? 32'b001 : 32'b011);
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
